// File: rtl/sa3_operand_loader.sv
// sa3_operand_loader: fetches a 3x3 filter and a 4x4 input tile from a single-port,
// 1-cycle-latency operand memory into holding registers. It then presents them to the
// 3x3 systolic array and runs the array until it reports completion.
//
// Handshake summary: start is sampled only in IDLE (a one-edge request, with no ready).
// mem_rd/mem_addr issue one read per cycle. mem_rdata is taken the cycle after its read.
// active_sa3 is a level request that stays high until done_sa3 is seen at an edge.
// tile_done is a single-cycle pulse on the return to IDLE.
module sa3_operand_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] flt_base,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] img_stride,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] a11, a12, a13, a14,
    output logic [DATA_W-1:0] a21, a22, a23, a24,
    output logic [DATA_W-1:0] a31, a32, a33, a34,
    output logic [DATA_W-1:0] a41, a42, a43, a44,
    output logic [DATA_W-1:0] b11, b12, b13,
    output logic [DATA_W-1:0] b21, b22, b23,
    output logic [DATA_W-1:0] b31, b32, b33,
    output logic              active_sa3,
    input  logic              done_sa3,
    output logic              busy,
    output logic              tile_done,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [4:0] LAST_ISSUE = 5'd24;
    localparam logic [4:0] FLT_WORDS  = 5'd9;

    state_t state_q;
    state_t state_d;

    // Index of the word currently on mem_addr: 0..8 filter, 9..24 tile.
    logic [4:0]        issue_n;
    // Issue index delayed by one cycle, lined up with mem_rdata.
    logic [4:0]        cap_idx;
    logic              cap_vld;
    logic [ADDR_W-1:0] flt_b;
    logic [ADDR_W-1:0] img_b;
    logic [ADDR_W-1:0] stride_r;
    // Operand holding registers: [0..8] filter row-major, [9..24] tile row-major.
    logic [DATA_W-1:0] op_q [25];

    logic [4:0]        issue_next;
    logic [3:0]        img_i;
    logic [ADDR_W-1:0] addr_next;

    // Address of the next word to issue, from the bases latched at start.
    always_comb begin
        issue_next = issue_n + 5'd1;
        img_i      = 4'(issue_next - FLT_WORDS);
        addr_next  = '0;
        if (issue_next < FLT_WORDS) begin
            addr_next = flt_b + ADDR_W'(issue_next);
        end else begin
            addr_next = img_b + stride_r * ADDR_W'(img_i[3:2]) + ADDR_W'(img_i[1:0]);
        end
    end

    // Next-state logic for the load sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   if (issue_n == LAST_ISSUE) state_d = DRAIN;
            DRAIN:   state_d = RUN;
            RUN:     if (done_sa3) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read issue, capture pipeline and run/complete handshake registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            issue_n    <= '0;
            cap_idx    <= '0;
            cap_vld    <= 1'b0;
            flt_b      <= '0;
            img_b      <= '0;
            stride_r   <= '0;
            active_sa3 <= 1'b0;
            busy       <= 1'b0;
            tile_done  <= 1'b0;
            for (int j = 0; j < 25; j++) op_q[j] <= '0;
        end else begin
            tile_done <= 1'b0;
            cap_vld   <= mem_rd;
            cap_idx   <= issue_n;
            if (cap_vld) op_q[cap_idx] <= mem_rdata;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        flt_b    <= flt_base;
                        img_b    <= img_base;
                        stride_r <= img_stride;
                        mem_rd   <= 1'b1;
                        mem_addr <= flt_base;
                        issue_n  <= '0;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    if (issue_n == LAST_ISSUE) begin
                        mem_rd <= 1'b0;
                    end else begin
                        issue_n  <= issue_next;
                        mem_addr <= addr_next;
                    end
                end
                DRAIN: begin
                    active_sa3 <= 1'b1;
                end
                RUN: begin
                    if (done_sa3) begin
                        active_sa3 <= 1'b0;
                        busy       <= 1'b0;
                        tile_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbg_state = state_q;

    assign b11 = op_q[0];  assign b12 = op_q[1];  assign b13 = op_q[2];
    assign b21 = op_q[3];  assign b22 = op_q[4];  assign b23 = op_q[5];
    assign b31 = op_q[6];  assign b32 = op_q[7];  assign b33 = op_q[8];
    assign a11 = op_q[9];  assign a12 = op_q[10]; assign a13 = op_q[11]; assign a14 = op_q[12];
    assign a21 = op_q[13]; assign a22 = op_q[14]; assign a23 = op_q[15]; assign a24 = op_q[16];
    assign a31 = op_q[17]; assign a32 = op_q[18]; assign a33 = op_q[19]; assign a34 = op_q[20];
    assign a41 = op_q[21]; assign a42 = op_q[22]; assign a43 = op_q[23]; assign a44 = op_q[24];

endmodule

// File: tb/tb_sa3_operand_loader.sv
// Bench for sa3_operand_loader: memory responder, behavioural tile model,
// address scoreboard and directed tile scenarios.
module tb_sa3_operand_loader;
  localparam int DW = 8;
  localparam int AW = 10;

  // ---------------- clock / reset / DUT ----------------
  logic clk;
  logic rst;
  logic start;
  logic [AW-1:0] flt_base, img_base, img_stride;
  logic mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] a11, a12, a13, a14, a21, a22, a23, a24;
  logic [DW-1:0] a31, a32, a33, a34, a41, a42, a43, a44;
  logic [DW-1:0] b11, b12, b13, b21, b22, b23, b31, b32, b33;
  logic active_sa3, done_sa3, busy, tile_done;
  logic [1:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sa3_operand_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .flt_base(flt_base), .img_base(img_base), .img_stride(img_stride),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .a11(a11), .a12(a12), .a13(a13), .a14(a14),
    .a21(a21), .a22(a22), .a23(a23), .a24(a24),
    .a31(a31), .a32(a32), .a33(a33), .a34(a34),
    .a41(a41), .a42(a42), .a43(a43), .a44(a44),
    .b11(b11), .b12(b12), .b13(b13),
    .b21(b21), .b22(b22), .b23(b23),
    .b31(b31), .b32(b32), .b33(b33),
    .active_sa3(active_sa3), .done_sa3(done_sa3),
    .busy(busy), .tile_done(tile_done), .dbg_state(dbg_state)
  );

  logic [DW-1:0] dut_op [25];
  assign dut_op[0] = b11;  assign dut_op[1] = b12;  assign dut_op[2] = b13;
  assign dut_op[3] = b21;  assign dut_op[4] = b22;  assign dut_op[5] = b23;
  assign dut_op[6] = b31;  assign dut_op[7] = b32;  assign dut_op[8] = b33;
  assign dut_op[9] = a11;  assign dut_op[10] = a12; assign dut_op[11] = a13; assign dut_op[12] = a14;
  assign dut_op[13] = a21; assign dut_op[14] = a22; assign dut_op[15] = a23; assign dut_op[16] = a24;
  assign dut_op[17] = a31; assign dut_op[18] = a32; assign dut_op[19] = a33; assign dut_op[20] = a34;
  assign dut_op[21] = a41; assign dut_op[22] = a42; assign dut_op[23] = a43; assign dut_op[24] = a44;

  // ---------------- operand memory (1-cycle read latency) ----------------
  logic [DW-1:0] tb_mem [1024];
  always @(posedge clk) begin
    if (mem_rd === 1'b1) mem_rdata <= tb_mem[mem_addr];
  end

  // ---------------- model and scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_q [$];
  logic [DW-1:0] exp_ops [25];
  logic [DW-1:0] prev_ops [25];
  logic [AW-1:0] last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Address scoreboard: every read strobe must match the next expected address.
  always @(negedge clk) begin
    logic [AW-1:0] e;
    if (rst === 1'b1 && mem_rd === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_addr: unexpected read at %0d, none expected", mem_addr);
      end else begin
        e = exp_q.pop_front();
        chk("mem_addr", 32'(mem_addr), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_active"}, 32'(active_sa3), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_tile_done"}, 32'(tile_done), 0);
    for (int j = 0; j < 25; j++) chk($sformatf("%s_op%0d", tag, j), 32'(dut_op[j]), 0);
  endtask

  // Called just after a falling edge: requests a tile and builds its expectations.
  task automatic start_tile(input int flt, input int img, input int stride);
    int a;
    for (int j = 0; j < 25; j++) prev_ops[j] = exp_ops[j];
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        a = (flt + 3 * r + c) % 1024;
        exp_ops[r * 3 + c] = tb_mem[a];
        exp_q.push_back(AW'(a));
      end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        a = (img + r * stride + c) % 1024;
        exp_ops[9 + r * 4 + c] = tb_mem[a];
        exp_q.push_back(AW'(a));
        last_addr = AW'(a);
      end
    flt_base   = AW'(flt);
    img_base   = AW'(img);
    img_stride = AW'(stride);
    start      = 1'b1;
  endtask

  // Runs one tile from its T0 edge; done_sa3 is pulsed in cycle d.
  // abort_k>0 pulls reset in cycle abort_k instead. chain>0 requests the next tile
  // in the tile_done cycle.
  task automatic run_tile(input int d, input bit noise, input int abort_k, input bit chain,
                          input int nf, input int ni, input int ns);
    logic [DW-1:0] e;
    @(posedge clk);
    for (int k = 1; k <= d + 1; k++) begin
      @(negedge clk);
      if (abort_k > 0 && k == abort_k + 1) begin
        chk_all_zero("abort");
        rst = 1'b1;
        exp_q.delete();
        for (int j = 0; j < 25; j++) begin
          exp_ops[j] = '0;
          prev_ops[j] = '0;
        end
        return;
      end
      chk($sformatf("mem_rd_k%0d", k), 32'(mem_rd), 32'(k <= 25));
      chk($sformatf("busy_k%0d", k), 32'(busy), 32'(k <= d));
      chk($sformatf("active_k%0d", k), 32'(active_sa3), 32'(k >= 27 && k <= d));
      chk($sformatf("tile_done_k%0d", k), 32'(tile_done), 32'(k == d + 1));
      if (k == 26) chk("drain_addr_hold", 32'(mem_addr), 32'(last_addr));
      for (int j = 0; j < 25; j++) begin
        e = (k >= j + 3) ? exp_ops[j] : prev_ops[j];
        chk($sformatf("op%0d_k%0d", j, k), 32'(dut_op[j]), 32'(e));
      end
      start    = noise && (k == 5 || k == 30);
      done_sa3 = (k == d) || (noise && k == 10);
      rst      = !(abort_k > 0 && k == abort_k);
      if (k == d + 1) begin
        chk("addr_seq_consumed", 32'(exp_q.size()), 0);
        if (chain) start_tile(nf, ni, ns);
      end
    end
  endtask

  task automatic idle_cycles(input int n, input bit pulse_done);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_mem_rd", 32'(mem_rd), 0);
      chk("idle_tile_done", 32'(tile_done), 0);
      chk("idle_active", 32'(active_sa3), 0);
      done_sa3 = pulse_done && (i == 0);
    end
    done_sa3 = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    for (int i = 0; i < 1024; i++) tb_mem[i] = DW'(i + 1);
    for (int j = 0; j < 25; j++) begin
      exp_ops[j] = '0;
      prev_ops[j] = '0;
    end
    last_addr  = '0;
    rst        = 1'b0;
    start      = 1'b1;
    done_sa3   = 1'b0;
    flt_base   = '0;
    img_base   = '0;
    img_stride = '0;

    // Reset held with start high.
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst   = 1'b1;
    start = 1'b0;
    idle_cycles(4, 1'b1);

    // Basic load.
    start_tile(0, 16, 4);
    run_tile(40, 1'b0, 0, 1'b0, 0, 0, 0);
    chk("basic_b11", 32'(b11), 1);
    chk("basic_b33", 32'(b33), 9);
    chk("basic_a11", 32'(a11), 17);
    chk("basic_a44", 32'(a44), 32);
    idle_cycles(2, 1'b0);

    // Image address wrap, with stray start/done pulses.
    start_tile(100, 1020, 1);
    run_tile(30, 1'b1, 0, 1'b0, 0, 0, 0);
    chk("wrap_b11", 32'(b11), 101);
    chk("wrap_a11", 32'(a11), 253);
    chk("wrap_a14", 32'(a14), 0);
    chk("wrap_a21", 32'(a21), 254);
    chk("wrap_a24", 32'(a24), 1);
    chk("wrap_a44", 32'(a44), 3);
    idle_cycles(2, 1'b0);

    // Zero stride, then back-to-back into a second tile.
    start_tile(9, 50, 0);
    run_tile(28, 1'b0, 0, 1'b1, 500, 200, 37);
    run_tile(33, 1'b0, 0, 1'b0, 0, 0, 0);
    chk("b2b_b11", 32'(b11), 245);
    chk("b2b_a21", 32'(a21), 238);
    chk("b2b_a44", 32'(a44), 59);
    idle_cycles(2, 1'b0);

    // Reset in the middle of the fetch, then a full load.
    start_tile(0, 16, 4);
    run_tile(40, 1'b0, 12, 1'b0, 0, 0, 0);
    idle_cycles(2, 1'b0);
    start_tile(3, 700, 8);
    run_tile(29, 1'b0, 0, 1'b0, 0, 0, 0);
    chk("post_abort_b11", 32'(b11), 4);
    chk("post_abort_a11", 32'(a11), 189);
    idle_cycles(2, 1'b0);

    chk("final_addr_queue", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
